// File: rtl/day2_pkg.sv
// -----------------------------------------------------------------------------
// day2_pkg
//   Shared types and helpers for the day-2 demux router slice.
//   - dest_e       : destination select encoding (matches the day-1 mux:
//                    sel=1 -> A, sel=0 -> B)
//   - fifo_state_e : occupancy class of a destination FIFO
//   - ptr_w()      : pointer width for a FIFO of a given depth
// -----------------------------------------------------------------------------
package day2_pkg;

  typedef enum logic {
    DEST_B = 1'b0,
    DEST_A = 1'b1
  } dest_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    if (depth > 1) begin
      return $clog2(depth);
    end
    return 1;
  endfunction

endpackage

// File: rtl/day2_sync_fifo.sv
// -----------------------------------------------------------------------------
// day2_sync_fifo
//   Small synchronous FIFO, one per router destination. Head entry is read
//   straight from storage, so a beat written at edge N is first visible as the
//   head after edge N; there is no write-to-read bypass.
//
// Parameters
//   DATA_W  data width
//   DEPTH   entries (power of two, >= 2)
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_i    in   synchronous active-high reset (empties FIFO, zeroes storage)
//   push_i   in   write data_i this cycle (ignored when full)
//   data_i   in   write data
//   pop_i    in   drop the head entry this cycle (ignored when empty)
//   full_o   out  occupancy == DEPTH
//   empty_o  out  occupancy == 0
//   head_o   out  oldest stored entry
// -----------------------------------------------------------------------------
module day2_sync_fifo
  import day2_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  fifo_state_e       state;
  logic              do_push;
  logic              do_pop;

  // Occupancy class derived purely from the registered count.
  always_comb begin
    state = FIFO_PARTIAL;
    if (count == '0) begin
      state = FIFO_EMPTY;
    end else if (count == FULL_CNT) begin
      state = FIFO_FULL;
    end
  end

  assign full_o  = (state == FIFO_FULL);
  assign empty_o = (state == FIFO_EMPTY);
  assign head_o  = mem[rd_ptr];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so plain
  // increment wraps modulo DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/day2_demux_router.sv
// -----------------------------------------------------------------------------
// day2_demux_router
//   Steers one valid/ready input stream to one of two output streams by a
//   per-beat select (sel=1 -> A, sel=0 -> B). Each destination owns a small
//   FIFO so a stalled consumer only blocks beats addressed to it. Delivered
//   beats are counted per destination with saturating counters.
//
// Parameters
//   DATA_W  data width on every stream
//   DEPTH   entries per destination FIFO (power of two, >= 2)
//   CNT_W   width of the delivered-beat counters
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_i       in   synchronous active-high reset
//   in_valid_i  in   input beat valid
//   in_ready_o  out  input beat accepted when valid & ready
//   in_data_i   in   input data
//   in_sel_i    in   destination, 1 = A, 0 = B
//   a_valid_o   out  A stream valid
//   a_ready_i   in   A consumer ready
//   a_data_o    out  A stream data
//   b_valid_o   out  B stream valid
//   b_ready_i   in   B consumer ready
//   b_data_o    out  B stream data
//   a_count_o   out  beats delivered on A, saturating
//   b_count_o   out  beats delivered on B, saturating
// -----------------------------------------------------------------------------
module day2_demux_router
  import day2_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sel_i,
  output logic              a_valid_o,
  input  logic              a_ready_i,
  output logic [DATA_W-1:0] a_data_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  output logic [DATA_W-1:0] b_data_o,
  output logic [CNT_W-1:0]  a_count_o,
  output logic [CNT_W-1:0]  b_count_o
);

  dest_e dest;
  logic  a_full;
  logic  a_empty;
  logic  b_full;
  logic  b_empty;
  logic  push_a;
  logic  push_b;
  logic  pop_a;
  logic  pop_b;

  assign dest = dest_e'(in_sel_i);

  // Ready depends only on the select and registered FIFO occupancy; a
  // same-cycle pop of a full FIFO does not open the input.
  always_comb begin
    in_ready_o = 1'b0;
    if (!rst_i) begin
      unique case (dest)
        DEST_A:  in_ready_o = !a_full;
        DEST_B:  in_ready_o = !b_full;
        default: in_ready_o = 1'b0;
      endcase
    end
  end

  assign push_a = in_valid_i && in_ready_o && (dest == DEST_A);
  assign push_b = in_valid_i && in_ready_o && (dest == DEST_B);

  assign a_valid_o = !a_empty;
  assign b_valid_o = !b_empty;
  assign pop_a     = a_valid_o && a_ready_i;
  assign pop_b     = b_valid_o && b_ready_i;

  day2_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_a),
    .data_i  (in_data_i),
    .pop_i   (pop_a),
    .full_o  (a_full),
    .empty_o (a_empty),
    .head_o  (a_data_o)
  );

  day2_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_b),
    .data_i  (in_data_i),
    .pop_i   (pop_b),
    .full_o  (b_full),
    .empty_o (b_empty),
    .head_o  (b_data_o)
  );

  // Delivered-beat counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_count_o <= '0;
      b_count_o <= '0;
    end else begin
      if (pop_a && (a_count_o != '1)) begin
        a_count_o <= a_count_o + CNT_W'(1);
      end
      if (pop_b && (b_count_o != '1)) begin
        b_count_o <= b_count_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_day2_demux_router.sv
module tb_day2_demux_router;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEP   = 2;
  localparam int unsigned CW    = 4;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_sel = 1'b0;
  logic          a_valid;
  logic          a_ready = 1'b0;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready = 1'b0;
  logic [DW-1:0] b_data;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  int checks = 0;
  int failures = 0;

  // Reference model: one queue per destination plus plain integer counters.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int unsigned   ca = 0;
  int unsigned   cb = 0;
  bit            last_accept = 1'b0;

  always #5 clk = ~clk;

  day2_demux_router #(
    .DATA_W (DW),
    .DEPTH  (DEP),
    .CNT_W  (CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_sel_i   (in_sel),
    .a_valid_o  (a_valid),
    .a_ready_i  (a_ready),
    .a_data_o   (a_data),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .b_data_o   (b_data),
    .a_count_o  (a_count),
    .b_count_o  (b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    if (rst) return 1'b0;
    return in_sel ? (qa.size() < DEP) : (qb.size() < DEP);
  endfunction

  task automatic compare_all();
    chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
    chk("a_valid", {31'b0, a_valid}, {31'b0, qa.size() > 0});
    chk("b_valid", {31'b0, b_valid}, {31'b0, qb.size() > 0});
    if (qa.size() > 0) chk("a_data", 32'(a_data), 32'(qa[0]));
    if (qb.size() > 0) chk("b_data", 32'(b_data), 32'(qb[0]));
    chk("a_count", 32'(a_count), ca);
    chk("b_count", 32'(b_count), cb);
  endtask

  // Apply inputs away from the active edge, then compare against the model.
  task automatic drive(input bit r, input bit v, input bit s, input logic [DW-1:0] d,
                       input bit ar, input bit br);
    @(negedge clk);
    rst = r; in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    #1;
    compare_all();
  endtask

  // Update the model for the coming edge, then take the edge.
  task automatic advance();
    bit acc;
    acc = in_valid && model_ready();
    if (rst) begin
      qa.delete(); qb.delete(); ca = 0; cb = 0;
    end else begin
      if (qa.size() > 0 && a_ready) begin
        void'(qa.pop_front());
        if (ca < CMAX) ca++;
      end
      if (qb.size() > 0 && b_ready) begin
        void'(qb.pop_front());
        if (cb < CMAX) cb++;
      end
      if (acc) begin
        if (in_sel) qa.push_back(in_data);
        else        qb.push_back(in_data);
      end
    end
    last_accept = acc;
    @(posedge clk);
  endtask

  task automatic step(input bit r, input bit v, input bit s, input logic [DW-1:0] d,
                      input bit ar, input bit br);
    drive(r, v, s, d, ar, br);
    advance();
  endtask

  initial begin
    bit            pv;
    bit            ps;
    logic [DW-1:0] pd;

    repeat (2) @(posedge clk);

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, '0, 1, 1);
      chk("rst_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_avalid", {31'b0, a_valid}, 32'd0);
      advance();
    end
    drive(0, 0, 1, '0, 1, 1);
    chk("rel_ready", {31'b0, in_ready}, 32'd1);
    chk("rel_adata", 32'(a_data), 32'd0);
    chk("rel_bdata", 32'(b_data), 32'd0);
    advance();

    // Route one beat to each destination.
    step(0, 1, 1, 8'hFF, 1, 1);
    drive(0, 1, 0, 8'h00, 1, 1);
    chk("route_a", 32'(a_data), 32'hFF);
    advance();
    drive(0, 0, 0, '0, 1, 1);
    chk("route_bv", {31'b0, b_valid}, 32'd1);
    chk("route_b", 32'(b_data), 32'h00);
    chk("route_acnt", 32'(a_count), 32'd1);
    advance();
    drive(0, 0, 0, '0, 1, 1);
    chk("route_bcnt", 32'(b_count), 32'd1);
    advance();

    // Backpressure on B, A keeps flowing.
    step(0, 1, 0, 8'h11, 1, 0);
    step(0, 1, 0, 8'h22, 1, 0);
    drive(0, 1, 0, 8'h33, 1, 0);
    chk("bp_stall", {31'b0, in_ready}, 32'd0);
    advance();
    drive(0, 1, 1, 8'h44, 1, 0);
    chk("bp_a_ready", {31'b0, in_ready}, 32'd1);
    advance();
    drive(0, 0, 0, '0, 1, 0);
    chk("bp_a_data", 32'(a_data), 32'h44);
    advance();

    // Full B popped the same cycle: input stays stalled, accepted next cycle.
    drive(0, 1, 0, 8'h33, 1, 1);
    chk("fp_stall", {31'b0, in_ready}, 32'd0);
    chk("fp_b11", 32'(b_data), 32'h11);
    advance();
    drive(0, 1, 0, 8'h33, 1, 1);
    chk("fp_accept", {31'b0, in_ready}, 32'd1);
    chk("fp_b22", 32'(b_data), 32'h22);
    advance();
    drive(0, 0, 0, '0, 1, 1);
    chk("fp_b33", 32'(b_data), 32'h33);
    advance();
    drive(0, 0, 0, '0, 1, 1);
    chk("fp_bempty", {31'b0, b_valid}, 32'd0);
    advance();

    // Reset with two beats parked in A.
    step(0, 1, 1, 8'hA1, 0, 1);
    step(0, 1, 1, 8'hA2, 0, 1);
    drive(1, 0, 1, '0, 0, 1);
    chk("mr_full_a", {31'b0, a_valid}, 32'd1);
    advance();
    drive(0, 0, 1, '0, 0, 1);
    chk("mr_avalid", {31'b0, a_valid}, 32'd0);
    advance();
    drive(0, 0, 1, '0, 1, 1);
    chk("mr_gone", {31'b0, a_valid}, 32'd0);
    advance();

    // Saturation: 20 beats delivered on A.
    for (int i = 0; i < 20; i++) step(0, 1, 1, DW'(i), 1, 1);
    repeat (3) step(0, 0, 1, '0, 1, 1);
    drive(0, 0, 1, '0, 1, 1);
    chk("sat_acnt", 32'(a_count), 32'hF);
    advance();

    // Randomized traffic; an unaccepted beat is held with its select.
    pv = 1'b0; ps = 1'b0; pd = '0;
    step(1, 0, 0, '0, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 99) == 0);
      if (r || !pv || last_accept) begin
        pv = ($urandom_range(0, 3) != 0);
        ps = 1'($urandom);
        pd = DW'($urandom);
      end
      step(r, pv, ps, pd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      if (r) pv = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
